if_fetch: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter register. It consumes the current `pc`, issues instruction-memory reads over a valid/ready handshake, and places each fetched instruction into the IF/ID pipeline register for decode. It also drives `pc_tmp`/`pc_en` back into the PC register, so it owns all PC sequencing: sequential +4 advance and redirects from execute.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_skid.sv | 44 ++++
 rtl/if_fetch.sv | 128 ++++++++++++
 tb/tb_if_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0100_0000;
    localparam logic [31:0] ILEN      = 32'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    localparam ifid_t IFID_RESET = '{pc: RESET_PC, instr: INSTR_NOP};

endpackage

// File: rtl/if_fetch_skid.sv
// IF/ID pipeline register with a one-entry skid buffer behind it; flush empties both.
module if_fetch_skid
    import if_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  push,
    input  ifid_t push_data,
    input  logic  out_ready,
    output logic  out_valid,
    output ifid_t out_data,
    output logic  buf_valid
);

    ifid_t buf_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            buf_valid <= 1'b0;
            out_data  <= IFID_RESET;
            buf_data  <= IFID_RESET;
        end else if (flush) begin
            out_valid <= 1'b0;
            buf_valid <= 1'b0;
        end else if (buf_valid) begin
            // buffer only fills while the register is full, so out_valid stays set
            if (out_ready) begin
                out_data  <= buf_data;
                buf_valid <= 1'b0;
            end
        end else if (push && (!out_valid || out_ready)) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
        end else if (push) begin
            buf_data  <= push_data;
            buf_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues imem reads at pc, sequences pc (+ILEN / redirect), fills IF/ID.
// Optional misaligned-fetch trap: define IF_FETCH_MISALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | after reset, go to REQ next cycle
//   REQ   | request valid at pc (or held address after a redirect) until handshake
//   WAIT  | waiting for the response; drop it if kill is set
//   HOLD  | response parked in skid buffer until decode takes IF/ID
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_tmp,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    fetch_state_t state;
    logic         kill;
    logic         hold;
    logic [31:0]  hold_addr;
    logic         buf_valid;
    logic         misalign;
    logic         req_fire;
    logic         accept;
    logic         direct;
    logic [31:0]  req_pc;
    logic [31:0]  redir_pc;
    ifid_t        ifid_q;

    // after a redirect the outstanding request keeps its old address
    assign req_pc = hold ? hold_addr : pc;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    assign misalign  = (state == REQ) && !hold && (pc[1:0] != 2'b00);
    assign redir_pc  = redirect_target;
    assign imem_addr = req_pc;
`else
    logic unused_lsb;
    assign unused_lsb = ^{redirect_target[1:0], req_pc[1:0]};
    assign misalign   = 1'b0;
    assign redir_pc   = {redirect_target[31:2], 2'b00};
    assign imem_addr  = {req_pc[31:2], 2'b00};
`endif

    assign imem_req_valid = (state == REQ) && !misalign;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign accept         = (state == WAIT) && imem_rsp_valid && !kill && !redirect_valid;
    assign direct         = !ifid_valid || ifid_ready;
    assign pc_en          = redirect_valid || accept;
    assign pc_tmp         = redirect_valid ? redir_pc : pc + ILEN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            kill      <= 1'b0;
            hold      <= 1'b0;
            hold_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        state <= WAIT;
                        hold  <= 1'b0;
                        if (redirect_valid) kill <= 1'b1;
                    end else if (redirect_valid && imem_req_valid) begin
                        kill <= 1'b1;
                        if (!hold) begin
                            hold      <= 1'b1;
                            hold_addr <= pc;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= (redirect_valid || kill || direct) ? REQ : HOLD;
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: if (redirect_valid || ifid_ready) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                fetch_fault <= 1'b0;
        else if (redirect_valid) fetch_fault <= 1'b0;
        else if (misalign)       fetch_fault <= 1'b1;
    end
`endif

    if_fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (accept),
        .push_data ('{pc: pc, instr: imem_rsp_data}),
        .out_ready (ifid_ready),
        .out_valid (ifid_valid),
        .out_data  (ifid_q),
        .buf_valid (buf_valid)
    );

    assign ifid_pc    = ifid_q.pc;
    assign ifid_instr = ifid_q.instr;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus misalign and reset-in-WAIT sequences.
`timescale 1ns/1ps
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_tmp;
    logic        pc_en;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ifid_valid;
    logic        ifid_ready = 1'b1;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // PC register the stage drives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       pc <= 32'h0100_0000;
        else if (pc_en) pc <= pc_tmp;
    end

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_tmp          (pc_tmp),
        .pc_en           (pc_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .ifid_valid      (ifid_valid),
        .ifid_ready      (ifid_ready),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr)
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] data;
        logic        ir;
        logic        rd;
        logic [31:0] tgt;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_pe;
        logic [31:0] e_tmp;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    localparam logic [31:0] D0 = 32'hC0DE_0000;

    task automatic drive(input logic rr, input logic rv, input logic [31:0] d,
                         input logic ir, input logic rd, input logic [31:0] tg);
        imem_req_ready  = rr;
        imem_rsp_valid  = rv;
        imem_rsp_data   = d;
        ifid_ready      = ir;
        redirect_valid  = rd;
        redirect_target = tg;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] base;
        //           rr rv data     ir rd tgt           | rv addr          pe tmp           iv ipc           ins
        vecs[0]  = '{0, 0, 0,       1, 0, 0,            0, 0,            0, 0,            0, 0,            0};
        vecs[1]  = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0000, 0, 0,           0, 0,            0};
        vecs[2]  = '{0, 1, D0+0,    1, 0, 0,            0, 0,            1, 32'h0100_0004, 0, 0,           0};
        vecs[3]  = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0004, 0, 0,           1, 32'h0100_0000, D0+0};
        vecs[4]  = '{0, 1, D0+1,    1, 0, 0,            0, 0,            1, 32'h0100_0008, 0, 0,           0};
        vecs[5]  = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0008, 0, 0,           1, 32'h0100_0004, D0+1};
        vecs[6]  = '{0, 1, D0+2,    1, 0, 0,            0, 0,            1, 32'h0100_000C, 0, 0,           0};
        vecs[7]  = '{0, 0, 0,       1, 0, 0,            1, 32'h0100_000C, 0, 0,           1, 32'h0100_0008, D0+2};
        vecs[8]  = '{0, 0, 0,       1, 0, 0,            1, 32'h0100_000C, 0, 0,           0, 0,            0};
        vecs[9]  = '{0, 0, 0,       1, 0, 0,            1, 32'h0100_000C, 0, 0,           0, 0,            0};
        vecs[10] = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_000C, 0, 0,           0, 0,            0};
        vecs[11] = '{0, 1, D0+3,    0, 0, 0,            0, 0,            1, 32'h0100_0010, 0, 0,           0};
        vecs[12] = '{1, 0, 0,       0, 0, 0,            1, 32'h0100_0010, 0, 0,           1, 32'h0100_000C, D0+3};
        vecs[13] = '{0, 1, D0+4,    0, 0, 0,            0, 0,            1, 32'h0100_0014, 1, 32'h0100_000C, D0+3};
        vecs[14] = '{1, 0, 0,       0, 0, 0,            0, 0,            0, 0,            1, 32'h0100_000C, D0+3};
        vecs[15] = '{1, 0, 0,       1, 0, 0,            0, 0,            0, 0,            1, 32'h0100_000C, D0+3};
        vecs[16] = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0014, 0, 0,           1, 32'h0100_0010, D0+4};
        vecs[17] = '{0, 0, 0,       1, 1, 32'h0100_0100, 0, 0,           1, 32'h0100_0100, 0, 0,           0};
        vecs[18] = '{0, 1, D0+5,    1, 0, 0,            0, 0,            0, 0,            0, 0,            0};
        vecs[19] = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0100, 0, 0,           0, 0,            0};
        vecs[20] = '{0, 1, D0+6,    1, 0, 0,            0, 0,            1, 32'h0100_0104, 0, 0,           0};
        vecs[21] = '{0, 0, 0,       1, 1, 32'hFFFF_FFFC, 1, 32'h0100_0104, 1, 32'hFFFF_FFFC, 1, 32'h0100_0100, D0+6};
        vecs[22] = '{1, 0, 0,       1, 0, 0,            1, 32'h0100_0104, 0, 0,           0, 0,            0};
        vecs[23] = '{0, 1, D0+7,    1, 0, 0,            0, 0,            0, 0,            0, 0,            0};
        vecs[24] = '{1, 0, 0,       1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,           0, 0,            0};
        vecs[25] = '{0, 1, D0+8,    1, 0, 0,            0, 0,            1, 32'h0000_0000, 0, 0,           0};
        vecs[26] = '{0, 0, 0,       1, 0, 0,            1, 32'h0000_0000, 0, 0,           1, 32'hFFFF_FFFC, D0+8};

        // reset state
        next_cycle();
        #1;
        chk("reset req_valid", imem_req_valid, 0);
        chk("reset pc_en", pc_en, 0);
        chk("reset ifid_valid", ifid_valid, 0);
        chk("reset ifid_pc", ifid_pc, RESET_PC);
        chk("reset ifid_instr", ifid_instr, INSTR_NOP);
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        chk("reset fetch_fault", fetch_fault, 0);
`endif
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rr, vecs[i].rv, vecs[i].data, vecs[i].ir, vecs[i].rd, vecs[i].tgt);
            #1;
            chk($sformatf("row%0d req_valid", i), imem_req_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("row%0d pc_en", i), pc_en, vecs[i].e_pe);
            if (vecs[i].e_pe) chk($sformatf("row%0d pc_tmp", i), pc_tmp, vecs[i].e_tmp);
            chk($sformatf("row%0d ifid_valid", i), ifid_valid, vecs[i].e_iv);
            if (vecs[i].e_iv) begin
                chk($sformatf("row%0d ifid_pc", i), ifid_pc, vecs[i].e_ipc);
                chk($sformatf("row%0d ifid_instr", i), ifid_instr, vecs[i].e_ins);
            end
            next_cycle();
        end

        // redirect to a misaligned target while the request in REQ is accepted
        drive(1, 0, 0, 1, 1, 32'h0100_0102);
        #1;
        chk("mis redirect pc_en", pc_en, 1);
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        chk("mis redirect pc_tmp", pc_tmp, 32'h0100_0102);
        base = 32'h0100_0200;
`else
        chk("mis redirect pc_tmp", pc_tmp, 32'h0100_0100);
        base = 32'h0100_0100;
`endif
        next_cycle();
        drive(0, 1, D0+9, 1, 0, 0);
        #1;
        chk("mis killed rsp pc_en", pc_en, 0);
        next_cycle();

`ifdef IF_FETCH_MISALIGN_TRAP_EN
        drive(1, 0, 0, 1, 0, 0);
        #1;
        chk("mis req suppressed", imem_req_valid, 0);
        next_cycle();
        drive(1, 0, 0, 1, 1, 32'h0100_0200);
        #1;
        chk("mis fault raised", fetch_fault, 1);
        chk("mis req still suppressed", imem_req_valid, 0);
        chk("mis clear pc_en", pc_en, 1);
        next_cycle();
        drive(1, 0, 0, 1, 0, 0);
        #1;
        chk("mis fault cleared", fetch_fault, 0);
`else
        drive(1, 0, 0, 1, 0, 0);
        #1;
`endif
        chk("post req_valid", imem_req_valid, 1);
        chk("post imem_addr", imem_addr, base);
        next_cycle();
        drive(0, 1, D0+10, 0, 0, 0);
        #1;
        chk("post accept pc_tmp", pc_tmp, base + 32'd4);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0);
        #1;
        chk("post ifid_valid", ifid_valid, 1);
        chk("post ifid_pc", ifid_pc, base);
        chk("post imem_addr2", imem_addr, base + 32'd4);
        next_cycle();

        // reset asserted asynchronously while in WAIT
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst req_valid", imem_req_valid, 0);
        chk("async rst pc_en", pc_en, 0);
        chk("async rst ifid_valid", ifid_valid, 0);
        chk("async rst ifid_pc", ifid_pc, RESET_PC);
        chk("async rst ifid_instr", ifid_instr, INSTR_NOP);
        next_cycle();
        rst = 1'b1;
        drive(0, 1, D0+11, 1, 0, 0);
        #1;
        chk("stale rsp idle pc_en", pc_en, 0);
        chk("stale rsp idle ifid_valid", ifid_valid, 0);
        next_cycle();
        drive(0, 1, D0+11, 1, 0, 0);
        #1;
        chk("stale rsp req_valid", imem_req_valid, 1);
        chk("stale rsp imem_addr", imem_addr, RESET_PC);
        chk("stale rsp pc_en", pc_en, 0);
        chk("stale rsp ifid_valid", ifid_valid, 0);
        next_cycle();
        drive(0, 0, 0, 1, 0, 0);
        #1;
        chk("stale rsp ifid_valid later", ifid_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
